// File: rtl/alu_pkg.sv
// Shared types for the ALU writeback path: op codes, the two-beat op marker
// and the queued result record.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_MUL  = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLT  = 4'b1001,
        ALU_SLTU = 4'b1010,
        ALU_CMP  = 4'b1011,
        ALU_EQ   = 4'b1100,
        ALU_LT   = 4'b1101,
        ALU_NE   = 4'b1110
    } alu_op_e;

    localparam logic [3:0] OP_MUL = ALU_MUL;

    // Tag field is sized for the widest supported register index; TAG_W <= MAX_TAG_W.
    localparam int MAX_TAG_W = 8;

    typedef struct packed {
        logic [63:0]          result;
        logic [3:0]           op;
        logic                 v;
        logic                 c;
        logic [MAX_TAG_W-1:0] tag;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous queue of ALU results; head entry is visible combinationally
// so the consumer can load it in the same cycle it pops.
module wb_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  wb_entry_t                push_data_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Queues ALU results and serialises each into 32-bit register-file write beats
// (two for multiply), updating the architectural V/C/Z/N flags on the last beat.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_result,
    input  logic [3:0]       in_op,
    input  logic             in_v,
    input  logic             in_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_hi,
    output logic             wb_last,
    output logic             flag_v,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its payload stable until that edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10
    } state_e;

    state_e                state_q;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  unused_head_tag;

    logic [63:0]           res_q;
    logic                  mul_q;
    logic                  v_q;
    logic                  c_q;
    logic [TAG_W-1:0]      tag_q;

    logic                  wb_valid_q;
    logic [31:0]           wb_data_q;
    logic [TAG_W-1:0]      wb_tag_q;
    logic                  wb_hi_q;
    logic                  wb_last_q;
    logic                  flag_v_q;
    logic                  flag_c_q;
    logic                  flag_z_q;
    logic                  flag_n_q;

    logic                  beat_done;
    logic                  advance;
    logic                  pop;
    logic                  flag_upd;
    logic                  next_z;
    logic                  next_n;

    always_comb begin
        push_entry        = '0;
        push_entry.result = in_result;
        push_entry.op     = in_op;
        push_entry.v      = in_v;
        push_entry.c      = in_c;
        push_entry.tag    = MAX_TAG_W'(in_tag);
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (in_valid),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign unused_head_tag = ^head.tag;

    // A multiply's low beat moves to HI without popping; every other finished
    // beat pops the next entry directly so back-to-back ops have no bubble.
    always_comb begin
        beat_done = wb_valid_q & wb_ready;
        advance   = beat_done & ~((state_q == ST_LO) & mul_q);
        pop       = ~fifo_empty & ((state_q == ST_IDLE) | advance);
        flag_upd  = beat_done & wb_last_q;
        next_z    = mul_q ? (res_q == 64'd0) : (res_q[31:0] == 32'd0);
        next_n    = mul_q ? res_q[63] : res_q[31];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            res_q      <= '0;
            mul_q      <= 1'b0;
            v_q        <= 1'b0;
            c_q        <= 1'b0;
            tag_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
            wb_hi_q    <= 1'b0;
            wb_last_q  <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else begin
            if (flag_upd) begin
                flag_v_q <= v_q;
                flag_c_q <= c_q;
                flag_z_q <= next_z;
                flag_n_q <= next_n;
            end
            if (pop) begin
                state_q    <= ST_LO;
                res_q      <= head.result;
                mul_q      <= (head.op == OP_MUL);
                v_q        <= head.v;
                c_q        <= head.c;
                tag_q      <= head.tag[TAG_W-1:0];
                wb_valid_q <= 1'b1;
                wb_data_q  <= head.result[31:0];
                wb_tag_q   <= head.tag[TAG_W-1:0];
                wb_hi_q    <= 1'b0;
                wb_last_q  <= (head.op != OP_MUL);
            end else if (beat_done && (state_q == ST_LO) && mul_q) begin
                state_q    <= ST_HI;
                wb_data_q  <= res_q[63:32];
                wb_tag_q   <= tag_q + TAG_W'(1);
                wb_hi_q    <= 1'b1;
                wb_last_q  <= 1'b1;
            end else if (beat_done) begin
                state_q    <= ST_IDLE;
                wb_valid_q <= 1'b0;
                wb_data_q  <= '0;
                wb_tag_q   <= '0;
                wb_hi_q    <= 1'b0;
                wb_last_q  <= 1'b0;
            end
        end
    end

    assign in_ready = ~fifo_full;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_tag   = wb_tag_q;
    assign wb_hi    = wb_hi_q;
    assign wb_last  = wb_last_q;
    assign flag_v   = flag_v_q;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;
    assign flag_n   = flag_n_q;
    assign busy     = (fifo_count != '0) | (state_q != ST_IDLE);

endmodule
